// File: rtl/execute_wb_arbiter_if.sv
// Bundle of exe/ddr write-back requests and register-file / stride-file steering outputs.
// The master drives the pipeline side. The slave is the arbiter.
interface execute_wb_arbiter_if #(
  parameter int NUM_PORTS = 8,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int NUM_SRF   = 3
);
  logic                          exe_valid;
  logic                          exe_wen;
  logic                          exe_wide_wen;
  logic [ADDR_W-1:0]             exe_waddr;
  logic [DATA_W-1:0]             exe_wdata;
  logic [2*ADDR_W-1:0]           exe_raddr;
  logic [NUM_PORTS-1:0]          ddr_wen;
  logic [NUM_PORTS*ADDR_W-1:0]   ddr_waddr;
  logic [NUM_PORTS*DATA_W-1:0]   ddr_wdata;
  logic [NUM_PORTS*ADDR_W-1:0]   ddr_raddr;
  logic [NUM_PORTS-1:0]          rf_wen;
  logic [NUM_PORTS*ADDR_W-1:0]   rf_waddr;
  logic [NUM_PORTS*DATA_W-1:0]   rf_wdata;
  logic [NUM_PORTS*ADDR_W-1:0]   rf_raddr;
  logic                          rf_wide_wen;
  logic [ADDR_W-1:0]             rf_wide_offset;
  logic [NUM_SRF-1:0]            srf_wen;
  logic [DATA_W-1:0]             srf_value;
  logic [(2**ADDR_W)-1:0]        rf_pending;
  logic                          exe_stall;
  logic                          overflow_err;

  modport master (
    output exe_valid, exe_wen, exe_wide_wen, exe_waddr, exe_wdata, exe_raddr,
           ddr_wen, ddr_waddr, ddr_wdata, ddr_raddr,
    input  rf_wen, rf_waddr, rf_wdata, rf_raddr, rf_wide_wen, rf_wide_offset,
           srf_wen, srf_value, rf_pending, exe_stall, overflow_err
  );

  modport slave (
    input  exe_valid, exe_wen, exe_wide_wen, exe_waddr, exe_wdata, exe_raddr,
           ddr_wen, ddr_waddr, ddr_wdata, ddr_raddr,
    output rf_wen, rf_waddr, rf_wdata, rf_raddr, rf_wide_wen, rf_wide_offset,
           srf_wen, srf_value, rf_pending, exe_stall, overflow_err
  );
endinterface

// File: rtl/execute_wb_arbiter.sv
// Write-back arbiter for register-file port 0. Exe writes win this port, and DDR writes that lose
// are queued and drained in order. Exe writes are decoded to the stride file, and read ports 0/1 are steered.
module execute_wb_arbiter #(
  parameter int NUM_PORTS  = 8,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 4,
  parameter int NUM_SRF    = 3,
  parameter int PEND_DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  execute_wb_arbiter_if.slave  bus
);
  localparam int PTR_W   = $clog2(PEND_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int NUM_IDS = 2**ADDR_W;

  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              s2_exe;
  logic              overflow_q;
  logic [ADDR_W-1:0] q_addr [PEND_DEPTH];
  logic [DATA_W-1:0] q_data [PEND_DEPTH];

  logic is_srf_id, exe_srf, exe_p0;
  logic q_empty, q_full, pop, push_req, push, drop;

  assign is_srf_id = (32'(bus.exe_waddr) < NUM_SRF);
  assign exe_srf   = bus.exe_wen & ~bus.exe_wide_wen & is_srf_id;
  assign exe_p0    = bus.exe_wen & ~bus.exe_wide_wen & ~is_srf_id;

  assign q_empty  = (count == '0);
  assign q_full   = (count == CNT_W'(PEND_DEPTH));
  assign pop      = ~exe_p0 & ~q_empty;
  // A queued write already waiting forces the new DDR write behind it to keep FIFO order
  assign push_req = bus.ddr_wen[0] & (exe_p0 | ~q_empty);
  assign push     = push_req & (~q_full | pop);
  assign drop     = push_req & ~push;

  always_comb begin
    bus.rf_wen   = bus.ddr_wen;
    bus.rf_waddr = bus.ddr_waddr;
    bus.rf_wdata = bus.ddr_wdata;
    if (exe_p0) begin
      bus.rf_wen[0]             = 1'b1;
      bus.rf_waddr[ADDR_W-1:0]  = bus.exe_waddr;
      bus.rf_wdata[DATA_W-1:0]  = bus.exe_wdata;
    end else if (pop) begin
      bus.rf_wen[0]             = 1'b1;
      bus.rf_waddr[ADDR_W-1:0]  = q_addr[rd_ptr];
      bus.rf_wdata[DATA_W-1:0]  = q_data[rd_ptr];
    end
  end

  always_comb begin
    bus.srf_wen = '0;
    for (int i = 0; i < NUM_SRF; i++)
      bus.srf_wen[i] = exe_srf & (32'(bus.exe_waddr) == i);
  end

  assign bus.srf_value      = bus.exe_wdata;
  assign bus.rf_wide_wen    = bus.exe_wen & bus.exe_wide_wen;
  assign bus.rf_wide_offset = bus.exe_waddr;
  assign bus.exe_stall      = q_full;
  assign bus.overflow_err   = overflow_q;

  always_comb begin
    bus.rf_raddr = bus.ddr_raddr;
    if (s2_exe)
      bus.rf_raddr[2*ADDR_W-1:0] = bus.exe_raddr;
  end

  always_comb begin
    bus.rf_pending = '0;
    for (int i = 0; i < PEND_DEPTH; i++)
      if (CNT_W'(i) < count)
        bus.rf_pending[q_addr[rd_ptr + PTR_W'(i)]] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      s2_exe     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      s2_exe <= bus.exe_valid;
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Entry storage needs no reset; validity is tracked by the pointers and the count
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= bus.ddr_waddr[ADDR_W-1:0];
      q_data[wr_ptr] <= bus.ddr_wdata[DATA_W-1:0];
    end
  end
endmodule

// File: tb/tb_execute_wb_arbiter.sv
// Directed bench for execute_wb_arbiter. Expected port-0 writes are queued by the stimulus,
// and a monitor retires them against every observed rf_wen[0].
module tb_execute_wb_arbiter;
  localparam int NP = 8, DW = 32, AW = 4, NS = 3, PD = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  execute_wb_arbiter_if #(.NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .NUM_SRF(NS)) bus();

  execute_wb_arbiter #(.NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .NUM_SRF(NS), .PEND_DEPTH(PD))
    dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.exe_valid    = 1'b0;
    bus.exe_wen      = 1'b0;
    bus.exe_wide_wen = 1'b0;
    bus.exe_waddr    = '0;
    bus.exe_wdata    = '0;
    bus.exe_raddr    = '0;
    bus.ddr_wen      = '0;
    bus.ddr_waddr    = '0;
    bus.ddr_wdata    = '0;
    bus.ddr_raddr    = '0;
  endtask

  task automatic ddr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.ddr_wen[0]         = 1'b1;
    bus.ddr_waddr[AW-1:0]  = a;
    bus.ddr_wdata[DW-1:0]  = d;
  endtask

  task automatic exe_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.exe_wen   = 1'b1;
    bus.exe_waddr = a;
    bus.exe_wdata = d;
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (rst && bus.rf_wen[0]) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL port0_unexpected: got id %0d data 0x%0h, required no write",
                 bus.rf_waddr[AW-1:0], bus.rf_wdata[DW-1:0]);
      end else begin
        e = exp_q.pop_front();
        chk("port0_write", 64'({bus.rf_waddr[AW-1:0], bus.rf_wdata[DW-1:0]}), 64'(e));
      end
    end
  end

  initial begin
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_pending", 64'(bus.rf_pending), 64'h0);
    chk("reset_stall", 64'(bus.exe_stall), 64'h0);
    chk("reset_overflow", 64'(bus.overflow_err), 64'h0);
    chk("reset_rf_wen", 64'(bus.rf_wen), 64'h0);
    next_cycle();
    rst = 1'b1;

    // conflict and drain
    next_cycle(); idle_inputs();
    exe_wr(4'd5, 32'hA); ddr0(4'd7, 32'hB); expect_wr(4'd5, 32'hA);
    @(negedge clk);
    chk("conflict_srf_wen", 64'(bus.srf_wen), 64'h0);
    chk("conflict_pending_c0", 64'(bus.rf_pending), 64'h0);
    next_cycle(); idle_inputs(); expect_wr(4'd7, 32'hB);
    @(negedge clk);
    chk("conflict_pending_c1", 64'(bus.rf_pending), 64'h0080);
    next_cycle(); idle_inputs();
    @(negedge clk);
    chk("conflict_pending_c2", 64'(bus.rf_pending), 64'h0);

    // stride decode and wide write
    next_cycle(); idle_inputs();
    exe_wr(4'd1, 32'h40); ddr0(4'd9, 32'h99); expect_wr(4'd9, 32'h99);
    @(negedge clk);
    chk("stride_srf_wen", 64'(bus.srf_wen), 64'b010);
    chk("stride_srf_value", 64'(bus.srf_value), 64'h40);
    chk("stride_wide_wen", 64'(bus.rf_wide_wen), 64'h0);
    next_cycle(); idle_inputs();
    bus.exe_wen = 1'b1; bus.exe_wide_wen = 1'b1; bus.exe_waddr = 4'd6; bus.exe_wdata = 32'h77;
    @(negedge clk);
    chk("stride_not_queued", 64'(bus.rf_pending), 64'h0);
    chk("wide_wen", 64'(bus.rf_wide_wen), 64'h1);
    chk("wide_offset", 64'(bus.rf_wide_offset), 64'h6);
    chk("wide_srf_wen", 64'(bus.srf_wen), 64'h0);

    // ordering
    next_cycle(); idle_inputs();
    exe_wr(4'd8, 32'h1); ddr0(4'd10, 32'h10); expect_wr(4'd8, 32'h1);
    next_cycle(); idle_inputs();
    exe_wr(4'd8, 32'h2); ddr0(4'd11, 32'h11); expect_wr(4'd8, 32'h2);
    @(negedge clk);
    chk("order_pending_1", 64'(bus.rf_pending), 64'h0400);
    next_cycle(); idle_inputs();
    ddr0(4'd12, 32'h12); expect_wr(4'd10, 32'h10);
    @(negedge clk);
    chk("order_pending_2", 64'(bus.rf_pending), 64'h0C00);
    next_cycle(); idle_inputs(); expect_wr(4'd11, 32'h11);
    @(negedge clk);
    chk("order_pending_3", 64'(bus.rf_pending), 64'h1800);
    next_cycle(); idle_inputs(); expect_wr(4'd12, 32'h12);
    @(negedge clk);
    chk("order_pending_4", 64'(bus.rf_pending), 64'h1000);
    next_cycle(); idle_inputs();
    @(negedge clk);
    chk("order_pending_5", 64'(bus.rf_pending), 64'h0);

    // full and overflow
    for (int k = 0; k < 4; k++) begin
      next_cycle(); idle_inputs();
      exe_wr(4'd4, DW'(k)); ddr0(AW'(12 + k), DW'(32'h100 + k)); expect_wr(4'd4, DW'(k));
      @(negedge clk);
      chk("full_stall_low", 64'(bus.exe_stall), 64'h0);
    end
    next_cycle(); idle_inputs();
    exe_wr(4'd4, 32'h55); ddr0(4'd15, 32'hFF); expect_wr(4'd4, 32'h55);
    @(negedge clk);
    chk("full_stall_high", 64'(bus.exe_stall), 64'h1);
    chk("full_pending", 64'(bus.rf_pending), 64'hF000);
    chk("full_overflow_pre", 64'(bus.overflow_err), 64'h0);
    next_cycle(); idle_inputs(); expect_wr(4'd12, 32'h100);
    @(negedge clk);
    chk("overflow_set", 64'(bus.overflow_err), 64'h1);
    chk("overflow_pending", 64'(bus.rf_pending), 64'hF000);
    for (int k = 1; k < 4; k++) begin
      next_cycle(); idle_inputs(); expect_wr(AW'(12 + k), DW'(32'h100 + k));
    end
    next_cycle(); idle_inputs();
    @(negedge clk);
    chk("drained_stall", 64'(bus.exe_stall), 64'h0);
    chk("overflow_sticky", 64'(bus.overflow_err), 64'h1);
    chk("drained_pending", 64'(bus.rf_pending), 64'h0);

    // read steering and port pass-through
    next_cycle(); idle_inputs();
    bus.exe_valid = 1'b1;
    bus.exe_raddr = {4'd3, 4'd2};
    for (int i = 0; i < NP; i++) bus.ddr_raddr[i*AW +: AW] = AW'(i + 8);
    bus.ddr_wen[3] = 1'b1;
    bus.ddr_waddr[3*AW +: AW] = 4'd6;
    bus.ddr_wdata[3*DW +: DW] = 32'h33;
    @(negedge clk);
    chk("steer_c0_p0", 64'(bus.rf_raddr[0 +: AW]), 64'd8);
    chk("pass_wen3", 64'(bus.rf_wen[3]), 64'h1);
    chk("pass_waddr3", 64'(bus.rf_waddr[3*AW +: AW]), 64'd6);
    chk("pass_wdata3", 64'(bus.rf_wdata[3*DW +: DW]), 64'h33);
    next_cycle();
    bus.exe_valid = 1'b0; bus.ddr_wen = '0;
    @(negedge clk);
    chk("steer_c1_p0", 64'(bus.rf_raddr[0 +: AW]), 64'd2);
    chk("steer_c1_p1", 64'(bus.rf_raddr[AW +: AW]), 64'd3);
    chk("steer_c1_p2", 64'(bus.rf_raddr[2*AW +: AW]), 64'd10);
    next_cycle();
    @(negedge clk);
    chk("steer_c2_p0", 64'(bus.rf_raddr[0 +: AW]), 64'd8);
    chk("steer_c2_p1", 64'(bus.rf_raddr[AW +: AW]), 64'd9);

    // async reset mid-drain with three entries queued
    for (int k = 0; k < 4; k++) begin
      next_cycle(); idle_inputs();
      exe_wr(4'd5, DW'(k)); ddr0(AW'(1 + k), DW'(32'h200 + k)); expect_wr(4'd5, DW'(k));
    end
    next_cycle(); idle_inputs(); expect_wr(4'd1, 32'h200);
    next_cycle();
    chk("prereset_pending", 64'(bus.rf_pending), 64'h001C);
    #2 rst = 1'b0;
    #1;
    chk("async_pending", 64'(bus.rf_pending), 64'h0);
    chk("async_stall", 64'(bus.exe_stall), 64'h0);
    chk("async_overflow", 64'(bus.overflow_err), 64'h0);
    next_cycle();
    rst = 1'b1;
    repeat (5) next_cycle();
    @(negedge clk);
    chk("post_reset_pending", 64'(bus.rf_pending), 64'h0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/execute_wb_arbiter.md
# execute_wb_arbiter

Parametrised write-back and read-steering stage between the exe pipeline, the ddr pipeline and the N-port register file. When both pipelines target register-file write port 0 in the same cycle, the exe write wins and the DDR write is queued rather than muxed away. Queued writes drain in order on idle port-0 cycles, and a pending-register mask lets decode interlock. Exe writes to stride-register ids are decoded to the stride register file, and read ports 0/1 are steered to the exe pipeline one cycle after an exe issue.

## Interface
Parameters:
- NUM_PORTS, 8, register-file write/read ports (port 0 shared, ports 1..NUM_PORTS-1 DDR-only)
- DATA_W, 32, register data width
- ADDR_W, 4, register id width
- NUM_SRF, 3, ids 0..NUM_SRF-1 map to stride registers on the exe path
- PEND_DEPTH, 4, port-0 pending-write queue depth (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- exe_valid  in  1  exe uop issued this cycle
- exe_wen  in  1  exe register write
- exe_wide_wen  in  1  exe write targets wide register; exe_waddr is the offset
- exe_waddr  in  ADDR_W  exe write id / wide offset
- exe_wdata  in  DATA_W  exe write data
- exe_raddr  in  2*ADDR_W  exe read ids for ports 0,1
- ddr_wen  in  NUM_PORTS  per-port DDR update enables
- ddr_waddr  in  NUM_PORTS*ADDR_W  DDR update ids
- ddr_wdata  in  NUM_PORTS*DATA_W  DDR update data
- ddr_raddr  in  NUM_PORTS*ADDR_W  DDR read ids
- rf_wen  out  NUM_PORTS  register-file write enables
- rf_waddr  out  NUM_PORTS*ADDR_W  write ids
- rf_wdata  out  NUM_PORTS*DATA_W  write data
- rf_raddr  out  NUM_PORTS*ADDR_W  read ids
- rf_wide_wen  out  1  = exe_wen & exe_wide_wen
- rf_wide_offset  out  ADDR_W  = exe_waddr
- srf_wen  out  NUM_SRF  one-hot stride write
- srf_value  out  DATA_W  = exe_wdata
- rf_pending  out  2**ADDR_W  bit i set while a queued write to id i is outstanding
- exe_stall  out  1  queue full; decode must not issue exe writes
- overflow_err  out  1  sticky protocol-violation flag

## Operation
- exe_srf = exe_wen & ~exe_wide_wen & (exe_waddr < NUM_SRF). The corresponding srf_wen bit is set; no rf write occurs.
- exe_p0 = exe_wen & ~exe_wide_wen & ~(exe_waddr < NUM_SRF). The exe write owns port 0 this cycle.
- Ports 1..NUM_PORTS-1 are passed through from the DDR inputs unchanged and combinationally.
- Port-0 DDR write (ddr_wen[0]), resolved in this priority order:
  - If exe_p0 is set, the write is pushed to the queue.
  - Otherwise, if the queue is non-empty, the queue head drives port 0 and the new DDR write is pushed (FIFO order is preserved).
  - Otherwise the DDR write drives port 0 directly.
- Queue pop: when exe_p0=0 and count>0, the head drives port 0 (rf_wen[0]=1) and is removed.
- Push and pop may occur in the same cycle; count is then unchanged.
- exe_stall = (count == PEND_DEPTH).
- If a push is required while count == PEND_DEPTH (which requires exe_p0 asserted during a stall):
  - the exe write still wins;
  - the DDR write is dropped;
  - overflow_err sets and holds until reset.
- rf_pending: the OR of one-hot decodes of valid queue entry ids. It updates on the registered queue state, so a pushed id is visible the cycle after the push and cleared the cycle after the pop.
- Read steering: s2_exe <= exe_valid. rf_raddr ports 0,1 = s2_exe ? exe_raddr : ddr_raddr ports 0,1. Other ports always come from ddr_raddr.

## Timing
- Write paths are combinational from inputs and queue state; there is no added latency for unconflicted writes.
- A queued write retires no earlier than the cycle after its push; worst case is after count+1 idle port-0 cycles.
- Registered state: queue rd/wr pointers, count, s2_exe, overflow_err. All are 0 on rst low, asynchronously.
- Reset value of every output: rf_pending=0, exe_stall=0, overflow_err=0. All other outputs are combinational in the inputs, with no queue contribution while count=0.
- Reset asserted mid-operation discards all queued writes.
- Pointers wrap modulo PEND_DEPTH; count has width log2(PEND_DEPTH)+1.

## Test plan
- **Conflict and drain:** exe_wen=1, waddr=5, data=0xA; ddr_wen[0]=1, waddr=7, data=0xB in cycle 0 -> cycle 0: port 0 writes id 5 = 0xA. Cycle 1: rf_pending[7]=1, port 0 writes id 7 = 0xB. Cycle 2: rf_pending=0.
- **Stride decode:** exe write to id 1, data=0x40 -> srf_wen=3'b010, srf_value=0x40, rf_wen[0]=0. A concurrent DDR port-0 write goes direct, not queued.
- **Ordering:** with 2 entries queued, a new DDR port-0 write arrives on an idle cycle -> the head retires and the new write is enqueued. Retire order matches arrival order across 4 cycles.
- **Full/overflow:** 4 consecutive conflicts -> exe_stall=1 after the 4th push. A 5th conflict while stalled -> the exe write lands, the DDR write is dropped, and overflow_err=1 persists.
- **Read steering:** exe_valid=1 in cycle 0 with exe_raddr={3,2} -> in cycle 1, rf_raddr ports 0/1 = 2,3. In cycle 2 with exe_valid=0, the ports follow ddr_raddr.
- **Async reset:** rst low mid-drain with count=3 -> immediately count=0, rf_pending=0, exe_stall=0. No queued write appears after release.
